// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: steps T0..T7 per instruction and issues
// every datapath strobe from a registered control word.
module control_sequencer #(
    parameter int unsigned        OPW    = 5,
    parameter logic [OPW-1:0]     ADD_OP = OPW'(5'b00011)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           stop,
    input  logic [31:0]    ir,
    input  logic           con_ff,
    output logic           run,
    output logic           clear,
    output logic [OPW-1:0] alu_op,
    output logic           PCout,
    output logic           PCin,
    output logic           incPC,
    output logic           IRin,
    output logic           MARin,
    output logic           MDRin,
    output logic           MDRout,
    output logic           read,
    output logic           write,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           Cout,
    output logic           Yin,
    output logic           Zin,
    output logic           ZHighOut,
    output logic           ZLowOut,
    output logic           HIin,
    output logic           LOin,
    output logic           HIout,
    output logic           LOout,
    output logic           CONN_in,
    output logic           InPortOut,
    output logic           OutPortIn,
    output logic           jal_flag
);

    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10011);
    localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10100);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(5'b10101);
    localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10110);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10111);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11000);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b11001);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    typedef enum logic [3:0] {
        RST = 4'd0, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef struct packed {
        logic           run;
        logic           clear;
        logic [OPW-1:0] alu_op;
        logic pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out, read, write;
        logic gra, grb, grc, r_in, r_out, ba_out, c_out, y_in, z_in;
        logic zhigh_out, zlow_out, hi_in, lo_in, hi_out, lo_out;
        logic conn_in, inport_out, outport_in, jal_flag;
    } ctl_t;

    state_t         state, next_state, last;
    ctl_t           ctl_q, ctl_d;
    logic [OPW-1:0] op;
    logic           is_mem, is_alu, is_imm, is_md, is_un;
    logic           unused_ir;

    assign op        = ir[31 -: OPW];
    assign unused_ir = ^ir[31-OPW:0];

    assign is_mem = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    assign is_alu = (op >= OP_ADD) && (op <= OP_SHL);
    assign is_imm = (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_md  = (op == OP_MUL) || (op == OP_DIV);
    assign is_un  = (op == OP_NEG) || (op == OP_NOT);

    // Final execute step for each opcode; everything unlisted ends at T3.
    function automatic state_t last_step(input logic [OPW-1:0] o);
        state_t s;
        s = T3;
        if (o == OP_LD || o == OP_ST)                                    s = T7;
        else if (o == OP_MUL || o == OP_DIV || o == OP_BR)               s = T6;
        else if (o == OP_LDI || (o >= OP_ADD && o <= OP_ORI))            s = T5;
        else if (o == OP_NEG || o == OP_NOT || o == OP_JAL)              s = T4;
        return s;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= RST;
            ctl_q       <= '0;
            ctl_q.clear <= 1'b1;
        end else begin
            state <= next_state;
            ctl_q <= ctl_d;
        end
    end

    // Next state, then the control word for that state so it is registered alongside it.
    always_comb begin
        next_state = state;
        ctl_d      = '0;
        ctl_d.run  = 1'b1;
        last       = last_step(op);

        case (state)
            RST:  next_state = T0;
            T0:   next_state = T1;
            T1:   next_state = T2;
            T2:   next_state = T3;
            T3, T4, T5, T6, T7: begin
                if (state != last)        next_state = state_t'(4'(state) + 4'd1);
                else if (op == OP_HALT)   next_state = HALT;
                else if (stop)            next_state = HALT;
                else                      next_state = T0;
            end
            HALT:    next_state = HALT;
            default: next_state = RST;
        endcase

        case (next_state)
            RST: begin
                ctl_d.run   = 1'b0;
                ctl_d.clear = 1'b1;
            end
            HALT: ctl_d.run = 1'b0;
            T0: begin
                ctl_d.pc_out = 1'b1; ctl_d.mar_in = 1'b1; ctl_d.inc_pc = 1'b1;
                ctl_d.z_in   = 1'b1; ctl_d.alu_op = ADD_OP;
            end
            T1: begin
                ctl_d.zlow_out = 1'b1; ctl_d.pc_in = 1'b1;
                ctl_d.read     = 1'b1; ctl_d.mdr_in = 1'b1;
            end
            T2: begin
                ctl_d.mdr_out = 1'b1; ctl_d.ir_in = 1'b1;
            end
            T3: begin
                if (is_mem) begin
                    ctl_d.grb = 1'b1; ctl_d.ba_out = 1'b1; ctl_d.y_in = 1'b1;
                end else if (is_alu || is_imm) begin
                    ctl_d.grb = 1'b1; ctl_d.r_out = 1'b1; ctl_d.y_in = 1'b1;
                end else if (is_md) begin
                    ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.y_in = 1'b1;
                end else if (is_un) begin
                    ctl_d.grb = 1'b1; ctl_d.r_out = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu_op = op;
                end else if (op == OP_BR) begin
                    ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.conn_in = 1'b1;
                end else if (op == OP_JR) begin
                    ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.pc_in = 1'b1;
                end else if (op == OP_JAL) begin
                    ctl_d.pc_out = 1'b1; ctl_d.jal_flag = 1'b1; ctl_d.r_in = 1'b1;
                end else if (op == OP_IN) begin
                    ctl_d.inport_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1;
                end else if (op == OP_OUT) begin
                    ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.outport_in = 1'b1;
                end else if (op == OP_MFLO) begin
                    ctl_d.lo_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1;
                end else if (op == OP_MFHI) begin
                    ctl_d.hi_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1;
                end
            end
            T4: begin
                if (is_mem) begin
                    ctl_d.c_out = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu_op = ADD_OP;
                end else if (is_alu) begin
                    ctl_d.grc = 1'b1; ctl_d.r_out = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu_op = op;
                end else if (is_imm) begin
                    ctl_d.c_out = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu_op = op;
                end else if (is_md) begin
                    ctl_d.grb = 1'b1; ctl_d.r_out = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu_op = op;
                end else if (is_un) begin
                    ctl_d.zlow_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1;
                end else if (op == OP_BR) begin
                    ctl_d.pc_out = 1'b1; ctl_d.y_in = 1'b1;
                end else if (op == OP_JAL) begin
                    ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.pc_in = 1'b1;
                end
            end
            T5: begin
                if (op == OP_LD || op == OP_ST) begin
                    ctl_d.zlow_out = 1'b1; ctl_d.mar_in = 1'b1;
                end else if (op == OP_LDI || is_alu || is_imm) begin
                    ctl_d.zlow_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1;
                end else if (is_md) begin
                    ctl_d.zlow_out = 1'b1; ctl_d.lo_in = 1'b1;
                end else if (op == OP_BR) begin
                    ctl_d.c_out = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu_op = ADD_OP;
                end
            end
            T6: begin
                if (op == OP_LD) begin
                    ctl_d.read = 1'b1; ctl_d.mdr_in = 1'b1;
                end else if (op == OP_ST) begin
                    ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.mdr_in = 1'b1;
                end else if (is_md) begin
                    ctl_d.zhigh_out = 1'b1; ctl_d.hi_in = 1'b1;
                end else if (op == OP_BR && con_ff) begin
                    ctl_d.zlow_out = 1'b1; ctl_d.pc_in = 1'b1;
                end
            end
            T7: begin
                if (op == OP_LD) begin
                    ctl_d.mdr_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1;
                end else if (op == OP_ST) begin
                    ctl_d.write = 1'b1;
                end
            end
            default: ctl_d.run = 1'b0;
        endcase
    end

    assign run       = ctl_q.run;
    assign clear     = ctl_q.clear;
    assign alu_op    = ctl_q.alu_op;
    assign PCout     = ctl_q.pc_out;
    assign PCin      = ctl_q.pc_in;
    assign incPC     = ctl_q.inc_pc;
    assign IRin      = ctl_q.ir_in;
    assign MARin     = ctl_q.mar_in;
    assign MDRin     = ctl_q.mdr_in;
    assign MDRout    = ctl_q.mdr_out;
    assign read      = ctl_q.read;
    assign write     = ctl_q.write;
    assign Gra       = ctl_q.gra;
    assign Grb       = ctl_q.grb;
    assign Grc       = ctl_q.grc;
    assign Rin       = ctl_q.r_in;
    assign Rout      = ctl_q.r_out;
    assign BAout     = ctl_q.ba_out;
    assign Cout      = ctl_q.c_out;
    assign Yin       = ctl_q.y_in;
    assign Zin       = ctl_q.z_in;
    assign ZHighOut  = ctl_q.zhigh_out;
    assign ZLowOut   = ctl_q.zlow_out;
    assign HIin      = ctl_q.hi_in;
    assign LOin      = ctl_q.lo_in;
    assign HIout     = ctl_q.hi_out;
    assign LOout     = ctl_q.lo_out;
    assign CONN_in   = ctl_q.conn_in;
    assign InPortOut = ctl_q.inport_out;
    assign OutPortIn = ctl_q.outport_in;
    assign jal_flag  = ctl_q.jal_flag;

endmodule
